// File: rtl/poly_mem_arbiter_pkg.sv
// Shared encapsulation definitions for the polynomial memory arbiter:
// memory geometry defaults, requester indices and the ownership state type.
package poly_mem_arbiter_pkg;

   localparam int AW_DEF = 11;
   localparam int DW_DEF = 13;

   localparam int REQ_TS   = 0;
   localparam int REQ_MULT = 1;
   localparam int REQ_HASH = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/poly_mem_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req searching upward
// from ptr+1, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   always_comb begin
      found = |req;
      idx   = '0;
      // Scan from the farthest candidate down so the nearest one wins.
      for (int i = NREQ; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % NREQ]) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
         end
      end
   end

endmodule

// File: rtl/poly_mem_arbiter.sv
// Round-robin ownership arbiter for one shared coefficient memory, with an
// owner-steered memory port mux and sticky detection of non-owner writes.
module poly_mem_arbiter
   import poly_mem_arbiter_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF,
   parameter int IDW  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  rel,
   input  logic [NREQ*AW-1:0] rd_addr,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wdata,
   input  logic [NREQ-1:0]  we,
   output logic [NREQ-1:0]  gnt,
   output logic             busy,
   output logic [IDW-1:0]   owner,
   output logic [AW-1:0]    mem_read_address,
   output logic [AW-1:0]    mem_write_address,
   output logic [DW-1:0]    mem_input,
   output logic             write_enable,
   output logic             viol,
   output logic [IDW-1:0]   viol_id,
   output arb_state_t       dbg_state
);

   arb_state_t       r_state;
   logic [NREQ-1:0]  r_gnt;
   logic             r_busy;
   logic [IDW-1:0]   r_owner;
   logic [IDW-1:0]   r_ptr;
   logic             r_viol;
   logic [IDW-1:0]   r_viol_id;

   logic             w_found;
   logic [IDW-1:0]   w_pick;
   logic [NREQ-1:0]  w_owner_oh;
   logic [NREQ-1:0]  w_bad;
   logic [IDW-1:0]   w_bad_id;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
      .req   (req),
      .ptr   (r_ptr),
      .found (w_found),
      .idx   (w_pick)
   );

   assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

   // Any write enable not belonging to a current owner is a violation.
   always_comb begin
      w_bad    = we & ~(r_busy ? w_owner_oh : '0);
      w_bad_id = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_bad[k]) begin
            w_bad_id = k[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ARB_IDLE;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_owner   <= '0;
         r_ptr     <= IDW'(NREQ - 1);
         r_viol    <= 1'b0;
         r_viol_id <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_found) begin
                  r_state <= ARB_OWNED;
                  r_owner <= w_pick;
                  r_ptr   <= w_pick;
                  r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                  r_busy  <= 1'b1;
               end
            end
            ARB_OWNED: begin
               // ptr already holds the owner, so it drops to lowest priority.
               if (rel[r_owner]) begin
                  r_state <= ARB_IDLE;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
         if (|w_bad && !r_viol) begin
            r_viol    <= 1'b1;
            r_viol_id <= w_bad_id;
         end
      end
   end

   assign gnt               = r_gnt;
   assign busy              = r_busy;
   assign owner             = r_owner;
   assign viol              = r_viol;
   assign viol_id           = r_viol_id;
   assign dbg_state         = r_state;
   assign mem_read_address  = r_busy ? rd_addr[r_owner*AW +: AW] : '0;
   assign mem_write_address = r_busy ? wr_addr[r_owner*AW +: AW] : '0;
   assign mem_input         = r_busy ? wdata[r_owner*DW +: DW] : '0;
   assign write_enable      = r_busy & we[r_owner];

endmodule
